// File: rtl/dmem_ctrl.sv
// Data-memory controller between the memory stage and a single-port 32-bit SRAM.
// Stores complete in one cycle; loads take one SRAM cycle plus one extract/register cycle.
module dmem_ctrl #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              mem_r_ena_i,
  input  logic [31:0]       mem_r_addr_i,
  input  logic              mem_w_ena_i,
  input  logic [31:0]       mem_w_addr_i,
  input  logic [31:0]       mem_w_data_i,
  input  logic [2:0]        funct3_i,
  output logic [31:0]       mem_r_data_o,
  output logic              mem_r_valid_o,
  output logic              stall_o,
  output logic              misalign_o,
  output logic              sram_cs_o,
  output logic              sram_we_o,
  output logic [3:0]        sram_be_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic [31:0]       sram_wdata_o,
  input  logic [31:0]       sram_rdata_i
);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t     state;
  logic [1:0] lat_off;
  logic [2:0] lat_funct3;

  // funct3[1:0] encodes access size: 00 byte, 01 half, 10 word, 11 never legal.
  function automatic logic aligned(input logic [1:0] size_code, input logic [1:0] off);
    case (size_code)
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~off[0];
      2'b10:   aligned = (off == 2'b00);
      default: aligned = 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] word, input logic [1:0] off,
                                          input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  extract = {{24{b[7]}}, b};
      3'b100:  extract = {24'h0, b};
      3'b001:  extract = {{16{h[15]}}, h};
      3'b101:  extract = {16'h0, h};
      default: extract = word;
    endcase
  endfunction

  logic load_ok, store_ok, idle, do_store, do_load, bad_load, bad_req;

  assign load_ok  = (funct3_i[2:1] != 2'b11) && aligned(funct3_i[1:0], mem_r_addr_i[1:0]);
  assign store_ok = ~funct3_i[2] && aligned(funct3_i[1:0], mem_w_addr_i[1:0]);
  assign idle     = (state == IDLE);
  assign do_store = idle & mem_w_ena_i & store_ok;
  assign do_load  = idle & mem_r_ena_i & ~mem_w_ena_i & load_ok;
  assign bad_load = idle & mem_r_ena_i & ~mem_w_ena_i & ~load_ok;
  // A load colliding with a store is dropped and flagged even when the store itself is legal.
  assign bad_req  = (idle & mem_w_ena_i & (~store_ok | mem_r_ena_i)) | bad_load;

  // Address bits above the SRAM range are simply not routed, so accesses wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{mem_r_addr_i[31:ADDR_W+2], mem_w_addr_i[31:ADDR_W+2]};

  // NOTE: every output gets a default before the if/case so no path leaves it unassigned (no latch).
  always_comb begin
    sram_cs_o    = 1'b0;
    sram_we_o    = 1'b0;
    sram_be_o    = 4'b0000;
    sram_wdata_o = 32'h0;
    sram_addr_o  = mem_r_addr_i[ADDR_W+1:2];
    stall_o      = 1'b0;
    // The strobes are decoded straight from the request, so reset must mask them directly.
    if (arst_n) begin
      if (do_store) begin
        sram_cs_o   = 1'b1;
        sram_we_o   = 1'b1;
        sram_addr_o = mem_w_addr_i[ADDR_W+1:2];
        case (funct3_i[1:0])
          2'b00: begin
            sram_be_o    = 4'b0001 << mem_w_addr_i[1:0];
            sram_wdata_o = {4{mem_w_data_i[7:0]}};
          end
          2'b01: begin
            sram_be_o    = 4'b0011 << mem_w_addr_i[1:0];
            sram_wdata_o = {2{mem_w_data_i[15:0]}};
          end
          default: begin
            sram_be_o    = 4'b1111;
            sram_wdata_o = mem_w_data_i;
          end
        endcase
      end else if (do_load) begin
        sram_cs_o = 1'b1;
        sram_be_o = 4'b1111;
        stall_o   = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state         <= IDLE;
      lat_off       <= 2'b00;
      lat_funct3    <= 3'b000;
      mem_r_data_o  <= 32'h0;
      mem_r_valid_o <= 1'b0;
      misalign_o    <= 1'b0;
    end else begin
      mem_r_valid_o <= 1'b0;
      misalign_o    <= bad_req;
      case (state)
        IDLE: begin
          if (do_load) begin
            state      <= RD_WAIT;
            lat_off    <= mem_r_addr_i[1:0];
            lat_funct3 <= funct3_i;
          end else if (bad_load) begin
            mem_r_data_o  <= 32'h0;
            mem_r_valid_o <= 1'b1;
          end
        end
        RD_WAIT: begin
          mem_r_data_o  <= extract(sram_rdata_i, lat_off, lat_funct3);
          mem_r_valid_o <= 1'b1;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: byte-level memory model, directed literal cases,
// then randomized load/store traffic compared every cycle.
module tb_dmem_ctrl;

  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              arst_n;
  logic              mem_r_ena_i;
  logic [31:0]       mem_r_addr_i;
  logic              mem_w_ena_i;
  logic [31:0]       mem_w_addr_i;
  logic [31:0]       mem_w_data_i;
  logic [2:0]        funct3_i;
  logic [31:0]       mem_r_data_o;
  logic              mem_r_valid_o;
  logic              stall_o;
  logic              misalign_o;
  logic              sram_cs_o;
  logic              sram_we_o;
  logic [3:0]        sram_be_o;
  logic [ADDR_W-1:0] sram_addr_o;
  logic [31:0]       sram_wdata_o;
  logic [31:0]       sram_rdata_i;

  always #5 clk = ~clk;

  dmem_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .arst_n(arst_n),
    .mem_r_ena_i(mem_r_ena_i), .mem_r_addr_i(mem_r_addr_i),
    .mem_w_ena_i(mem_w_ena_i), .mem_w_addr_i(mem_w_addr_i), .mem_w_data_i(mem_w_data_i),
    .funct3_i(funct3_i),
    .mem_r_data_o(mem_r_data_o), .mem_r_valid_o(mem_r_valid_o),
    .stall_o(stall_o), .misalign_o(misalign_o),
    .sram_cs_o(sram_cs_o), .sram_we_o(sram_we_o), .sram_be_o(sram_be_o),
    .sram_addr_o(sram_addr_o), .sram_wdata_o(sram_wdata_o), .sram_rdata_i(sram_rdata_i)
  );

  // SRAM device attached to the controller.
  logic [31:0] sram_mem [0:4095];
  logic [31:0] sram_tmp;
  always @(posedge clk) begin
    if (sram_cs_o) begin
      if (sram_we_o) begin
        sram_tmp = sram_mem[sram_addr_o];
        for (int j = 0; j < 4; j++)
          if (sram_be_o[j]) sram_tmp[8*j +: 8] = sram_wdata_o[8*j +: 8];
        sram_mem[sram_addr_o] <= sram_tmp;
      end else begin
        sram_rdata_i <= sram_mem[sram_addr_o];
      end
    end
  end

  // Reference model: flat byte memory plus expected outputs for the current cycle.
  logic [7:0]        model_mem [0:16383];
  bit                busy;
  bit                p1_v, p2_v, p1_m;
  logic [31:0]       p1_d, p2_d;
  logic              e_valid, e_mis, e_cs, e_we, e_stall;
  logic [31:0]       e_data, e_wdata;
  logic [3:0]        e_be;
  logic [ADDR_W-1:0] e_addr;
  bit                chk_en;
  int                n_tests, n_fail;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit legal(input logic [2:0] f3, input logic [1:0] off, input bit is_store);
    int size;
    if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b0;
    if (is_store && f3[2]) return 1'b0;
    size = 1 << f3[1:0];
    return (int'(off) % size) == 0;
  endfunction

  task automatic model_reset();
    busy = 0; p1_v = 0; p2_v = 0; p1_m = 0; p1_d = 0; p2_d = 0;
    e_valid = 0; e_mis = 0; e_data = 0; e_cs = 0; e_we = 0; e_stall = 0;
    e_be = 0; e_wdata = 0; e_addr = 0;
  endtask

  // Called once per cycle just after the rising edge: applies inputs and predicts outputs.
  task automatic drive(input bit re, input logic [31:0] ra, input bit we, input logic [31:0] wa,
                       input logic [31:0] wd, input logic [2:0] f3);
    int size;
    logic [31:0] v;
    e_valid = p1_v;
    if (p1_v) e_data = p1_d;
    e_mis = p1_m;
    p1_v = p2_v; p1_d = p2_d; p1_m = 0; p2_v = 0; p2_d = 0;
    mem_r_ena_i = re; mem_r_addr_i = ra; mem_w_ena_i = we; mem_w_addr_i = wa;
    mem_w_data_i = wd; funct3_i = f3;
    e_cs = 0; e_we = 0; e_stall = 0; e_be = 0; e_wdata = 0; e_addr = 0;
    size = 1 << f3[1:0];
    if (busy) begin
      busy = 0;
    end else if (we) begin
      if (legal(f3, wa[1:0], 1'b1)) begin
        e_cs = 1; e_we = 1; e_addr = wa[13:2];
        for (int i = 0; i < size; i++) begin
          e_be[int'(wa[1:0]) + i] = 1'b1;
          model_mem[int'(wa[13:0]) + i] = wd[8*i +: 8];
        end
        for (int j = 0; j < 4; j++) e_wdata[8*j +: 8] = wd[8*(j % size) +: 8];
      end else begin
        p1_m = 1;
      end
      if (re) p1_m = 1;
    end else if (re) begin
      if (legal(f3, ra[1:0], 1'b0)) begin
        e_cs = 1; e_stall = 1; e_be = 4'b1111; e_addr = ra[13:2];
        v = 0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = model_mem[int'(ra[13:0]) + i];
        if (!f3[2] && size < 4 && v[8*size-1])
          for (int k = 8*size; k < 32; k++) v[k] = 1'b1;
        p2_v = 1; p2_d = v; busy = 1;
      end else begin
        p1_m = 1; p1_v = 1; p1_d = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("valid",   mem_r_valid_o, e_valid);
      check("rdata",   mem_r_data_o,  e_data);
      check("misalign", misalign_o,   e_mis);
      check("stall",   stall_o,       e_stall);
      check("cs",      sram_cs_o,     e_cs);
      check("we",      sram_we_o,     e_we);
      check("be",      sram_be_o,     e_be);
      if (e_cs) check("addr", sram_addr_o, e_addr);
      if (e_we) check("wdata", sram_wdata_o, e_wdata);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask
  task automatic st(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    drive(0, 0, 1, a, d, f3); tick();
  endtask
  task automatic ld(input logic [31:0] a, input logic [2:0] f3);
    drive(1, a, 0, 0, 0, f3); tick();
  endtask
  task automatic nop();
    drive(0, 0, 0, 0, 0, 3'b000); tick();
  endtask
  task automatic expect_load(input string name, input logic [31:0] a, input logic [2:0] f3,
                             input logic [31:0] exp);
    ld(a, f3); nop();
    check({name, "_valid"}, mem_r_valid_o, 1'b1);
    check(name, mem_r_data_o, exp);
  endtask

  initial begin
    int kind;
    logic [2:0] f3;
    logic [31:0] ra, wa, wd;
    logic [2:0] legal_f3 [5];
    legal_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    n_tests = 0; n_fail = 0; chk_en = 0;
    for (int i = 0; i < 4096; i++) sram_mem[i] = 32'h0;
    for (int i = 0; i < 16384; i++) model_mem[i] = 8'h0;
    sram_rdata_i = 32'h0;
    model_reset();
    // Reset with a load request present: everything must read zero.
    arst_n = 0; mem_r_ena_i = 1; mem_r_addr_i = 32'h0; funct3_i = 3'b010;
    mem_w_ena_i = 0; mem_w_addr_i = 0; mem_w_data_i = 0;
    #12;
    check("rst_valid", mem_r_valid_o, 1'b0);
    check("rst_data",  mem_r_data_o,  32'h0);
    check("rst_mis",   misalign_o,    1'b0);
    check("rst_stall", stall_o,       1'b0);
    check("rst_cs",    sram_cs_o,     1'b0);
    check("rst_be",    sram_be_o,     4'b0000);
    @(posedge clk); #1;
    arst_n = 1; chk_en = 1;

    // SW then LW, stall for exactly one cycle, two-cycle latency.
    drive(0, 0, 1, 32'h10, 32'hDEADBEEF, 3'b010); #1;
    check("sw_be", sram_be_o, 4'b1111); tick();
    drive(1, 32'h10, 0, 0, 0, 3'b010); #1;
    check("lw_stall", stall_o, 1'b1); tick();
    drive(0, 0, 0, 0, 0, 3'b000); #1;
    check("lw_wait_stall", stall_o, 1'b0); tick();
    check("lw_valid", mem_r_valid_o, 1'b1);
    check("lw_data", mem_r_data_o, 32'hDEADBEEF);

    // Byte and halfword lanes with sign/zero extension.
    drive(0, 0, 1, 32'h13, 32'h80, 3'b000); #1;
    check("sb_be", sram_be_o, 4'b1000);
    check("sb_wdata", sram_wdata_o, 32'h80808080); tick();
    expect_load("lb",  32'h13, 3'b000, 32'hFFFFFF80);
    expect_load("lbu", 32'h13, 3'b100, 32'h00000080);
    drive(0, 0, 1, 32'h12, 32'h8001, 3'b001); #1;
    check("sh_be", sram_be_o, 4'b1100); tick();
    expect_load("lh",  32'h12, 3'b001, 32'hFFFF8001);
    expect_load("lhu", 32'h12, 3'b101, 32'h00008001);

    // Misaligned load and store, then a simultaneous load+store.
    drive(1, 32'h11, 0, 0, 0, 3'b010); #1;
    check("mis_lw_cs", sram_cs_o, 1'b0); tick();
    check("mis_lw_flag", misalign_o, 1'b1);
    check("mis_lw_valid", mem_r_valid_o, 1'b1);
    check("mis_lw_data", mem_r_data_o, 32'h0);
    drive(0, 0, 1, 32'h13, 32'h1234, 3'b001); #1;
    check("mis_sh_cs", sram_cs_o, 1'b0); tick();
    check("mis_sh_flag", misalign_o, 1'b1);
    drive(1, 32'h10, 1, 32'h14, 32'h5A5A5A5A, 3'b010); #1;
    check("rw_we", sram_we_o, 1'b1); tick();
    check("rw_flag", misalign_o, 1'b1);
    check("rw_novalid", mem_r_valid_o, 1'b0);

    // Address wrap above the SRAM range.
    st(32'h0000_4010, 32'h0BADF00D, 3'b010);
    expect_load("wrap", 32'h10, 3'b010, 32'h0BADF00D);

    // Back-to-back loads: the second is ignored during RD_WAIT and taken the cycle after.
    st(32'h0, 32'h11111111, 3'b010);
    st(32'h4, 32'h22222222, 3'b010);
    ld(32'h0, 3'b010);
    drive(1, 32'h4, 0, 0, 0, 3'b010); #1;
    check("b2b_hold_stall", stall_o, 1'b0);
    check("b2b_hold_cs", sram_cs_o, 1'b0); tick();
    check("b2b_first", mem_r_data_o, 32'h11111111);
    drive(1, 32'h4, 0, 0, 0, 3'b010); #1;
    check("b2b_accept", stall_o, 1'b1); tick();
    nop();
    check("b2b_second", mem_r_data_o, 32'h22222222);
    check("b2b_second_valid", mem_r_valid_o, 1'b1);

    // Reset while a load is in RD_WAIT.
    ld(32'h10, 3'b010);
    chk_en = 0;
    drive(1, 32'h10, 0, 0, 0, 3'b010);
    #2 arst_n = 0;
    #1;
    check("rw_rst_valid", mem_r_valid_o, 1'b0);
    check("rw_rst_data",  mem_r_data_o,  32'h0);
    check("rw_rst_stall", stall_o,       1'b0);
    check("rw_rst_cs",    sram_cs_o,     1'b0);
    check("rw_rst_be",    sram_be_o,     4'b0000);
    @(posedge clk); @(posedge clk); #1;
    model_reset();
    arst_n = 1; chk_en = 1;
    drive(0, 0, 1, 32'h24, 32'hCAFEF00D, 3'b010); #1;
    check("post_rst_sw", sram_we_o, 1'b1); tick();
    nop(); nop(); nop();
    expect_load("post_rst_lw", 32'h24, 3'b010, 32'hCAFEF00D);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      kind = $urandom_range(0, 9);
      f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : legal_f3[$urandom_range(0, 4)];
      ra = $urandom & 32'hFFFF_C0FF;
      wa = $urandom & 32'hFFFF_C0FF;
      wd = $urandom;
      case (kind)
        0, 1:    drive(0, ra, 0, wa, wd, f3);
        2, 3, 4: drive(1, ra, 0, wa, wd, f3);
        5, 6, 7: drive(0, ra, 1, wa, wd, f3);
        default: drive(1, ra, 1, wa, wd, f3);
      endcase
      tick();
    end
    nop(); nop();
    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter ADDR_W, default 12, SRAM word-address width (4096 x 32-bit words).
REQ-002 clk  input  1  core clock; all state updates on rising edge.
REQ-003 arst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 mem_r_ena_i  input  1  load request from the memory stage.
REQ-005 mem_r_addr_i  input  32  load byte address.
REQ-006 mem_w_ena_i  input  1  store request from the memory stage.
REQ-007 mem_w_addr_i  input  32  store byte address.
REQ-008 mem_w_data_i  input  32  store data, right-aligned.
REQ-009 funct3_i  input  3  access type: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU.
REQ-010 mem_r_data_o  output  32  extended load result, registered.
REQ-011 mem_r_valid_o  output  1  one-cycle pulse, mem_r_data_o valid.
REQ-012 stall_o  output  1  combinational hold request to the pipeline.
REQ-013 misalign_o  output  1  one-cycle registered pulse, misaligned or illegal access.
REQ-014 sram_cs_o / sram_we_o  output  1 / 1  SRAM select and write strobe.
REQ-015 sram_be_o  output  4  byte-lane enables.
REQ-016 sram_addr_o  output  ADDR_W  word address, taken from byte address [ADDR_W+1:2].
REQ-017 sram_wdata_o  output  32  lane-replicated store data.
REQ-018 sram_rdata_i  input  32  SRAM read data, valid one cycle after a read strobe.

Function
REQ-019 The FSM SHALL have exactly two states: IDLE and RD_WAIT.
REQ-020 Store in IDLE: complete in a single cycle with sram_cs_o=1, sram_we_o=1, stall_o=0, and no state change.
REQ-021 Store lanes: SB byte addr[1:0] sets be=0001<<addr[1:0] with data replicated x4; SH sets be=0011<<addr[1:0] with data replicated x2; SW sets be=1111.
REQ-022 Load in IDLE: drive sram_cs_o=1, sram_we_o=0, sram_be_o=1111, stall_o=1, and move to RD_WAIT.
REQ-023 In RD_WAIT: select the byte or halfword lane of sram_rdata_i by the latched addr[1:0], sign-extend (LB, LH) or zero-extend (LBU, LHU), register into mem_r_data_o, pulse mem_r_valid_o, hold stall_o=0, and return to IDLE.
REQ-024 Load latency: 2 cycles from request to mem_r_valid_o; throughput is 1 load per 2 cycles.
REQ-025 Address and funct3 SHALL be latched at request; input changes during RD_WAIT are ignored.
REQ-026 Requests arriving during RD_WAIT are not accepted; the pipeline holds them (stall released in that cycle, re-sampled in IDLE next cycle).
REQ-027 Misalignment (half with addr[0]=1, word with addr[1:0]!=0) or an illegal funct3 (011, 110, 111; 1xx for stores) SHALL produce no SRAM access, pulse misalign_o next cycle, keep stall_o=0, and for a load return mem_r_data_o=0 with mem_r_valid_o pulsed.
REQ-028 When read and write are simultaneous, the store executes and the load is dropped, with misalign_o pulsed.
REQ-029 Address bits above ADDR_W+1 are ignored (address wraps).
REQ-030 Outside an access, sram_cs_o=0, sram_we_o=0, and sram_be_o=0000.

Reset
REQ-031 arst_n=0 SHALL immediately force IDLE, mem_r_data_o=0, mem_r_valid_o=0, misalign_o=0, stall_o=0, sram_cs_o=0, sram_we_o=0, and sram_be_o=0.
REQ-032 A reset during RD_WAIT discards the pending load; no valid pulse after release.
REQ-033 The first request is accepted on the first rising edge after arst_n rises.

Verification
REQ-034 SW 0xDEADBEEF at 0x10, then LW 0x10 -> be=1111; 2 cycles later mem_r_valid_o=1 and mem_r_data_o=0xDEADBEEF; stall_o high exactly 1 cycle.
REQ-035 SB 0x80 at 0x13, then LB 0x13 -> be=1000 with wdata 0x80808080; load returns 0xFFFFFF80; LBU returns 0x00000080.
REQ-036 SH 0x8001 at 0x12, then LH 0x12 -> be=1100; LH returns 0xFFFF8001; LHU returns 0x00008001.
REQ-037 LW at 0x11 and SH at 0x13 -> sram_cs_o stays 0; misalign_o pulses; load data is 0.
REQ-038 Issue LW, then drop arst_n in RD_WAIT -> all outputs are 0 at once; after release no mem_r_valid_o pulse; the next SW succeeds.
REQ-039 Back-to-back LW 0x0 and LW 0x4 -> second is accepted 2 cycles after first; both data are correct, in order.
